// File: rtl/uart_tx_controller_if.sv
// ----------------------------------------------------------------------------
// uart_tx_controller_if
// Purpose : bundles the host write port and the uart_transmitter handshake of
//           uart_tx_controller into one interface.
// Modports:
//   master : drives wr_en_i, wr_data_i, flush_i, tx_en_i, trans_fi_i and
//            observes every status output (host / transmitter side)
//   slave  : the controller's view (takes the inputs, drives the outputs)
// Signals :
//   wr_en_i, wr_data_i[7:0]  byte push into the queue
//   flush_i                  empty the queue
//   tx_en_i                  allow new frames to start
//   trans_fi_i               frame-finished pulse from the transmitter
//   tx_data_o[7:0]           byte presented to the transmitter
//   start_tx_o               one-cycle start pulse to the transmitter
//   busy_o, full_o, empty_o  status flags
//   count_o                  queue occupancy
//   overflow_o, timeout_o    one-cycle event pulses
// ----------------------------------------------------------------------------
interface uart_tx_controller_if #(
  parameter int FIFO_DEPTH = 16
);

  localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

  logic               wr_en_i;
  logic [7:0]         wr_data_i;
  logic               flush_i;
  logic               tx_en_i;
  logic               trans_fi_i;
  logic [7:0]         tx_data_o;
  logic               start_tx_o;
  logic               busy_o;
  logic               full_o;
  logic               empty_o;
  logic [COUNT_W-1:0] count_o;
  logic               overflow_o;
  logic               timeout_o;

  modport master (
    output wr_en_i, wr_data_i, flush_i, tx_en_i, trans_fi_i,
    input  tx_data_o, start_tx_o, busy_o, full_o, empty_o, count_o,
           overflow_o, timeout_o
  );

  modport slave (
    input  wr_en_i, wr_data_i, flush_i, tx_en_i, trans_fi_i,
    output tx_data_o, start_tx_o, busy_o, full_o, empty_o, count_o,
           overflow_o, timeout_o
  );

endinterface

// File: rtl/uart_tx_controller.sv
// ----------------------------------------------------------------------------
// uart_tx_controller
// Purpose : byte queue and frame sequencer in front of uart_transmitter.
//           Host bytes are buffered in a FIFO; each one is popped onto
//           tx_data_o, announced with a one-cycle start_tx_o, and the next
//           frame waits for trans_fi_i plus an optional idle gap.
// Ports   :
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      uart_tx_controller_if.slave (write port, transmitter handshake,
//            status flags and event pulses)
// Parameters:
//   FIFO_DEPTH      queue entries, power of two >= 2
//   GAP_CYCLES      idle spacing after trans_fi_i (0 = none)
//   TIMEOUT_CYCLES  watchdog limit while waiting for trans_fi_i
// Build option:
//   UART_TX_CTRL_TIMEOUT_EN  when defined, a watchdog abandons a frame whose
//   trans_fi_i never arrives and pulses timeout_o; otherwise timeout_o is 0.
// ----------------------------------------------------------------------------
module uart_tx_controller #(
  parameter int FIFO_DEPTH     = 16,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  uart_tx_controller_if.slave bus
);

  localparam int ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int COUNT_W = ADDR_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1)
  begin : g_bad_params
    $error("uart_tx_controller: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT_FI, GAP} state_t;

  state_t             state, state_next;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
  logic [COUNT_W-1:0] count;
  logic [7:0]         tx_data;
  logic               overflow;
  logic [31:0]        gap_cnt;
  logic               full, empty, pop, push, drop;
  logic               wd_expire;
  logic               start_tx, busy;

  assign full  = (count == COUNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  // Flush outranks everything: it blocks the pop and swallows a same-cycle
  // write. A write into a full queue still lands when a pop frees the slot.
  assign pop  = (state == IDLE) && bus.tx_en_i && !empty && !bus.flush_i;
  assign push = bus.wr_en_i && !bus.flush_i && (!full || pop);
  assign drop = bus.wr_en_i && !bus.flush_i && full && !pop;

  // Queue pointers and occupancy; pointer wrap is free because the depth is
  // a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      if (push && !pop)      count <= count + COUNT_W'(1);
      else if (pop && !push) count <= count - COUNT_W'(1);
    end
  end

  // Storage array carries no reset; stale entries are unreachable once the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data_i;
  end

  // Registered byte to the transmitter, held until the next pop, and the
  // dropped-write indicator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (pop) tx_data <= mem[rd_ptr];
      overflow <= drop;
    end
  end

  // Gap timer. The cycle spent in IDLE deciding the next pop is the last
  // idle cycle, so GAP itself lasts GAP_CYCLES-1 cycles and the next start
  // lands GAP_CYCLES+1 cycles after trans_fi_i.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          gap_cnt <= '0;
    else if (state == GAP) gap_cnt <= gap_cnt + 32'd1;
    else                   gap_cnt <= '0;
  end

`ifdef UART_TX_CTRL_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        timeout;

  // A trans_fi_i arriving on the expiry cycle takes precedence.
  assign wd_expire = (state == WAIT_FI) && !bus.trans_fi_i &&
                     (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Watchdog counts cycles spent in WAIT_FI since entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == WAIT_FI) wd_cnt <= wd_cnt + 32'd1;
      else                  wd_cnt <= '0;
      timeout <= wd_expire;
    end
  end

  assign bus.timeout_o = timeout;
`else
  assign wd_expire     = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and decoded outputs.
  always_comb begin
    state_next = state;
    start_tx   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (pop) state_next = START;
      end
      START: begin
        start_tx   = 1'b1;
        state_next = WAIT_FI;
      end
      WAIT_FI: begin
        if (bus.trans_fi_i) state_next = (GAP_CYCLES > 1) ? GAP : IDLE;
        else if (wd_expire) state_next = IDLE;
      end
      GAP: begin
        if (gap_cnt == 32'(GAP_CYCLES - 2)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.tx_data_o  = tx_data;
  assign bus.start_tx_o = start_tx;
  assign bus.busy_o     = busy;
  assign bus.full_o     = full;
  assign bus.empty_o    = empty;
  assign bus.count_o    = count;
  assign bus.overflow_o = overflow;

endmodule

// File: tb/tb_uart_tx_controller.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_controller
// Purpose : self-checking bench for uart_tx_controller (FIFO_DEPTH=16,
//           GAP_CYCLES=3, TIMEOUT_CYCLES=50). A queue holds the bytes the
//           bench expects to see started; every start_tx_o pulse pops it and
//           compares tx_data_o. A vector table covers fill/overflow/wrap, and
//           hand-written sequences cover the multi-cycle corners.
// ----------------------------------------------------------------------------
module tb_uart_tx_controller;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic [7:0] sb [$];

  uart_tx_controller_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_controller #(
    .FIFO_DEPTH    (DEPTH),
    .GAP_CYCLES    (3),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  // Free-running clock and cycle index (index = number of rising edges seen).
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Safety net so the run always ends.
  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] global timeout");
  end

  typedef struct {
    logic       wr_en;
    logic [7:0] data;
    logic       tx_en;
    logic       accept;
    int         exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ovf;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [20];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic flush,
                               input logic txen, input logic fi);
    bus.wr_en_i    = wr;
    bus.wr_data_i  = data;
    bus.flush_i    = flush;
    bus.tx_en_i    = txen;
    bus.trans_fi_i = fi;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the cycle index of the next start pulse (current cycle included).
  task automatic waitStart(input string name, output int at);
    int n = 0;
    while (n < 30 && bus.start_tx_o !== 1'b1) begin
      tick();
      n++;
    end
    at = (bus.start_tx_o === 1'b1) ? cyc : -1;
    checkOutput({name, "_start_seen"}, (at >= 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Drives trans_fi_i for exactly one cycle; f is that cycle's index.
  task automatic pulseFi(output int f);
    f = cyc;
    bus.trans_fi_i = 1'b1;
    tick();
    bus.trans_fi_i = 1'b0;
  endtask

  // Scoreboard monitor: every start pulse must match the oldest queued byte.
  always @(negedge clk) begin
    if (bus.start_tx_o === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_start", 32'd1, 32'd0);
      end else begin
        checkOutput("start_data", {24'd0, bus.tx_data_o}, {24'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    int s, f, t, n;
    logic seen;

    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b1, 8'h10 + 8'(i), 1'b0, 1'b1, i + 1, (i == 15), 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 8'h99, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 8'hEE, 1'b1, 1'b1, 16, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset values.
    reset_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("rst_count", 32'(bus.count_o), 32'd0);
    checkOutput("rst_empty", 32'(bus.empty_o), 32'd1);
    checkOutput("rst_full", 32'(bus.full_o), 32'd0);
    checkOutput("rst_tx_data", 32'(bus.tx_data_o), 32'd0);
    checkOutput("rst_start", 32'(bus.start_tx_o), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("rst_ovf", 32'(bus.overflow_o), 32'd0);
    checkOutput("rst_timeout", 32'(bus.timeout_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();

    // Single byte latency.
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    sb.push_back(8'hA5);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("single_start_n", 32'(bus.start_tx_o), 32'd0);
    checkOutput("single_count_n", 32'(bus.count_o), 32'd1);
    tick();
    checkOutput("single_start_n1", 32'(bus.start_tx_o), 32'd1);
    checkOutput("single_data_n1", 32'(bus.tx_data_o), 32'hA5);
    checkOutput("single_count_n1", 32'(bus.count_o), 32'd0);
    tick();
    checkOutput("single_start_n2", 32'(bus.start_tx_o), 32'd0);
    checkOutput("single_busy_wait", 32'(bus.busy_o), 32'd1);
    pulseFi(f);
    checkOutput("single_busy_gap1", 32'(bus.busy_o), 32'd1);
    tick();
    checkOutput("single_busy_gap2", 32'(bus.busy_o), 32'd1);
    tick();
    checkOutput("single_busy_done", 32'(bus.busy_o), 32'd0);
    checkOutput("single_empty_done", 32'(bus.empty_o), 32'd1);

    // Burst of four with GAP_CYCLES=3.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      sb.push_back(8'(i));
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    waitStart("burst0", s);
    for (int k = 1; k <= 3; k++) begin
      repeat (3) tick();
      pulseFi(f);
      waitStart("burst", s);
      checkOutput("burst_spacing", 32'(s - f), 32'd4);
    end
    repeat (3) tick();
    pulseFi(f);
    repeat (2) tick();
    checkOutput("burst_busy_done", 32'(bus.busy_o), 32'd0);
    checkOutput("burst_empty_done", 32'(bus.empty_o), 32'd1);

    // Fill, overflow, push+pop at full, pointer wrap.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].wr_en, vecs[i].data, 1'b0, vecs[i].tx_en, 1'b0);
      if (vecs[i].accept) sb.push_back(vecs[i].data);
      tick();
      checkOutput($sformatf("vec%0d_count", i), 32'(bus.count_o), 32'(vecs[i].exp_count));
      checkOutput($sformatf("vec%0d_full", i), 32'(bus.full_o), 32'(vecs[i].exp_full));
      checkOutput($sformatf("vec%0d_empty", i), 32'(bus.empty_o), 32'(vecs[i].exp_empty));
      checkOutput($sformatf("vec%0d_ovf", i), 32'(bus.overflow_o), 32'(vecs[i].exp_ovf));
      checkOutput($sformatf("vec%0d_busy", i), 32'(bus.busy_o), 32'(vecs[i].exp_busy));
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    repeat (16) begin
      tick();
      pulseFi(f);
      waitStart("drain", s);
    end
    tick();
    pulseFi(f);
    repeat (2) tick();
    checkOutput("drain_busy_done", 32'(bus.busy_o), 32'd0);
    checkOutput("drain_empty_done", 32'(bus.empty_o), 32'd1);
    checkOutput("drain_sb_empty", 32'(sb.size()), 32'd0);

    // Flush beats pop in the same cycle.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'hC1 + 8'(i), 1'b0, 1'b0, 1'b0);
      sb.push_back(8'hC1 + 8'(i));
      tick();
    end
    checkOutput("flush_pre_count", 32'(bus.count_o), 32'd3);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    sb.delete();
    tick();
    checkOutput("flush_count", 32'(bus.count_o), 32'd0);
    checkOutput("flush_busy", 32'(bus.busy_o), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    checkOutput("flush_no_start_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("flush_still_empty", 32'(bus.empty_o), 32'd1);

    // Flush while a frame is in flight.
    applyStimulus(1'b1, 8'hD1, 1'b0, 1'b1, 1'b0);
    sb.push_back(8'hD1);
    tick();
    applyStimulus(1'b1, 8'hD2, 1'b0, 1'b1, 1'b0);
    sb.push_back(8'hD2);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    waitStart("fwait", s);
    tick();
    checkOutput("fwait_count", 32'(bus.count_o), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    sb.delete();
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("fwait_count_flushed", 32'(bus.count_o), 32'd0);
    checkOutput("fwait_busy_kept", 32'(bus.busy_o), 32'd1);
    checkOutput("fwait_data_kept", 32'(bus.tx_data_o), 32'hD1);
    pulseFi(f);
    repeat (2) tick();
    checkOutput("fwait_busy_done", 32'(bus.busy_o), 32'd0);
    repeat (3) tick();
    checkOutput("fwait_idle_after", 32'(bus.busy_o), 32'd0);

`ifdef UART_TX_CTRL_TIMEOUT_EN
    // Watchdog abandons the frame and the next byte starts.
    applyStimulus(1'b1, 8'hE1, 1'b0, 1'b1, 1'b0);
    sb.push_back(8'hE1);
    tick();
    applyStimulus(1'b1, 8'hE2, 1'b0, 1'b1, 1'b0);
    sb.push_back(8'hE2);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    waitStart("tmo", s);
    n = 0;
    while (n < 100 && bus.timeout_o !== 1'b1) begin
      tick();
      n++;
    end
    t = cyc;
    checkOutput("tmo_seen", 32'(bus.timeout_o), 32'd1);
    checkOutput("tmo_latency", 32'(t - s), 32'd51);
    waitStart("tmo_next", s);
    checkOutput("tmo_next_latency", 32'(s - t), 32'd1);
    tick();
    pulseFi(f);
    repeat (2) tick();
    checkOutput("tmo_busy_done", 32'(bus.busy_o), 32'd0);
`else
    // Without the watchdog a frame waits indefinitely.
    applyStimulus(1'b1, 8'hE1, 1'b0, 1'b1, 1'b0);
    sb.push_back(8'hE1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    waitStart("notmo", s);
    seen = 1'b0;
    repeat (60) begin
      tick();
      if (bus.timeout_o !== 1'b0) seen = 1'b1;
    end
    checkOutput("notmo_timeout", 32'(seen), 32'd0);
    checkOutput("notmo_busy", 32'(bus.busy_o), 32'd1);
    pulseFi(f);
    repeat (2) tick();
    checkOutput("notmo_busy_done", 32'(bus.busy_o), 32'd0);
`endif

    // Asynchronous reset during WAIT_FI with five bytes queued.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'hF0 + 8'(i), 1'b0, 1'b1, 1'b0);
      sb.push_back(8'hF0 + 8'(i));
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("rmid_count", 32'(bus.count_o), 32'd5);
    checkOutput("rmid_busy", 32'(bus.busy_o), 32'd1);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("rmid_async_count", 32'(bus.count_o), 32'd0);
    checkOutput("rmid_async_empty", 32'(bus.empty_o), 32'd1);
    checkOutput("rmid_async_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("rmid_async_data", 32'(bus.tx_data_o), 32'd0);
    checkOutput("rmid_async_start", 32'(bus.start_tx_o), 32'd0);
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) tick();
    checkOutput("rmid_post_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("rmid_post_count", 32'(bus.count_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
